// File: rtl/dac_pkg.sv
// Shared types and constants for the thermometer-code DAC receiver:
// FSM states, valid thermometer codes and the expected 8-sample frame.
package dac_pkg;

   localparam int unsigned CODE_W    = 4;
   localparam int unsigned LEVEL_W   = 3;
   localparam int unsigned PHASE_W   = 3;
   localparam int unsigned FRAME_LEN = 8;
   localparam int unsigned GOOD_W    = 4;
   localparam int unsigned MISS_W    = 3;
   localparam int unsigned ERR_W     = 8;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_LOCKED = 2'd2
   } rx_state_e;

   localparam logic [CODE_W-1:0] CODE_0 = 4'b0000;
   localparam logic [CODE_W-1:0] CODE_1 = 4'b0001;
   localparam logic [CODE_W-1:0] CODE_2 = 4'b0011;
   localparam logic [CODE_W-1:0] CODE_3 = 4'b0111;
   localparam logic [CODE_W-1:0] CODE_4 = 4'b1111;

   // Expected code per frame phase 0..7
   localparam logic [CODE_W-1:0] EXP_CODE [FRAME_LEN] = '{
      CODE_0, CODE_1, CODE_2, CODE_3, CODE_4, CODE_0, CODE_0, CODE_0
   };

   localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/thermo2bin.sv
// Combinational thermometer-to-binary decoder; any non-thermometer code
// decodes to level 0 with the bubble flag raised.
module thermo2bin
   import dac_pkg::*;
(
   input  logic [CODE_W-1:0]  code_i,
   output logic [LEVEL_W-1:0] level_c,
   output logic               bubble_c
);

   always_comb begin
      level_c  = '0;
      bubble_c = 1'b0;
      case (code_i)
         CODE_0:  level_c = 3'd0;
         CODE_1:  level_c = 3'd1;
         CODE_2:  level_c = 3'd2;
         CODE_3:  level_c = 3'd3;
         CODE_4:  level_c = 3'd4;
         default: bubble_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/dac_thermo_rx.sv
// Thermometer-code DAC receiver: decodes samples, aligns to the 8-sample
// frame, tracks lock and counts mismatches. DAC_THERMO_RX_SYNC_EN adds a
// 2-flop input synchronizer ahead of the sample register.
module dac_thermo_rx
   import dac_pkg::*;
#(
   parameter int unsigned LOCK_FRAMES = 2,
   parameter int unsigned MISS_LIMIT  = 3
) (
   input  logic               dac_clk,
   input  logic               dac_rst_n,
   input  logic               en,
   input  logic [CODE_W-1:0]  b_in,
   input  logic               err_clr,
   output logic [LEVEL_W-1:0] level,
   output logic               level_vld,
   output logic               bubble_err,
   output logic               lock,
   output logic               frame_done,
   output logic [ERR_W-1:0]   err_cnt
);

   localparam logic [GOOD_W-1:0] LOCK_FRAMES_C = GOOD_W'(LOCK_FRAMES);
   localparam logic [MISS_W-1:0] MISS_LIMIT_C  = MISS_W'(MISS_LIMIT);

   logic [CODE_W-1:0] b_src;

`ifdef DAC_THERMO_RX_SYNC_EN
   logic [CODE_W-1:0] sync1_q, sync2_q;

   // Synchronizer stages freeze with en so the whole pipeline holds together
   always_ff @(posedge dac_clk or negedge dac_rst_n) begin
      if (!dac_rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else if (en) begin
         sync1_q <= b_in;
         sync2_q <= sync1_q;
      end
   end

   assign b_src = sync2_q;
`else
   assign b_src = b_in;
`endif

   rx_state_e          state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [GOOD_W-1:0]  good_q, good_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic               prev_zero_q, prev_zero_d;
   logic [CODE_W-1:0]  b_q, b_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               vld_q, vld_d;
   logic               bub_q, bub_d;
   logic               lock_q, lock_d;
   logic               fd_q, fd_d;
   logic [ERR_W-1:0]   err_q, err_d;

   logic [LEVEL_W-1:0] dec_level;
   logic               dec_bubble;
   logic [PHASE_W-1:0] phase_nxt;
   logic [GOOD_W-1:0]  good_inc;
   logic [MISS_W-1:0]  miss_inc;
   logic               mismatch;
   logic               wrap;

   thermo2bin u_thermo2bin (
      .code_i   (b_q),
      .level_c  (dec_level),
      .bubble_c (dec_bubble)
   );

   always_ff @(posedge dac_clk or negedge dac_rst_n) begin
      if (!dac_rst_n) begin
         state_q     <= ST_HUNT;
         phase_q     <= '0;
         good_q      <= '0;
         miss_q      <= '0;
         prev_zero_q <= 1'b0;
         b_q         <= '0;
         level_q     <= '0;
         vld_q       <= 1'b0;
         bub_q       <= 1'b0;
         lock_q      <= 1'b0;
         fd_q        <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         good_q      <= good_d;
         miss_q      <= miss_d;
         prev_zero_q <= prev_zero_d;
         b_q         <= b_d;
         level_q     <= level_d;
         vld_q       <= vld_d;
         bub_q       <= bub_d;
         lock_q      <= lock_d;
         fd_q        <= fd_d;
         err_q       <= err_d;
      end
   end

   // phase_q is the frame phase of the last accepted sample; b_q is judged
   // against the code one phase later.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      good_d      = good_q;
      miss_d      = miss_q;
      prev_zero_d = prev_zero_q;
      b_d         = b_q;
      level_d     = level_q;
      bub_d       = bub_q;
      vld_d       = 1'b0;
      fd_d        = 1'b0;
      err_d       = err_q;

      phase_nxt = phase_q + 3'd1;
      good_inc  = good_q + 4'd1;
      miss_inc  = miss_q + 3'd1;
      mismatch  = (b_q != EXP_CODE[phase_nxt]);
      wrap      = (phase_q == 3'd7);

      if (en) begin
         b_d         = b_src;
         level_d     = dec_level;
         bub_d       = dec_bubble;
         vld_d       = 1'b1;
         prev_zero_d = (b_q == CODE_0);

         case (state_q)
            ST_HUNT: begin
               if (b_q == CODE_1 && prev_zero_q) begin
                  state_d = ST_ALIGN;
                  phase_d = 3'd1;
                  good_d  = '0;
               end
            end
            ST_ALIGN: begin
               if (mismatch) begin
                  state_d = ST_HUNT;
                  good_d  = '0;
               end else begin
                  phase_d = phase_nxt;
                  if (wrap) begin
                     if (good_inc >= LOCK_FRAMES_C) begin
                        state_d = ST_LOCKED;
                        good_d  = '0;
                        miss_d  = '0;
                     end else begin
                        good_d = good_inc;
                     end
                  end
               end
            end
            ST_LOCKED: begin
               phase_d = phase_nxt;
               fd_d    = wrap;
               if (mismatch) begin
                  if (err_q != ERR_MAX) begin
                     err_d = err_q + 8'd1;
                  end
                  if (miss_inc >= MISS_LIMIT_C) begin
                     state_d = ST_HUNT;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_inc;
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end

      // Clear takes priority over a same-cycle increment
      if (err_clr) begin
         err_d = '0;
      end

      lock_d = (state_d == ST_LOCKED);
   end

   assign level      = level_q;
   assign level_vld  = vld_q;
   assign bubble_err = bub_q;
   assign lock       = lock_q;
   assign frame_done = fd_q;
   assign err_cnt    = err_q;

endmodule

// File: tb/tb_dac_thermo_rx.sv
// Bench for dac_thermo_rx: decode table, directed lock/error sequences and
// randomized frames checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_dac_thermo_rx;

   localparam int LOCK_FRAMES = 2;
   localparam int MISS_LIMIT  = 3;
`ifdef DAC_THERMO_RX_SYNC_EN
   localparam int D = 3;
`else
   localparam int D = 1;
`endif
   localparam int LAT_EDGES = D + 1;

   logic       dac_clk = 1'b0;
   logic       dac_rst_n = 1'b0;
   logic       en = 1'b0;
   logic [3:0] b_in = 4'd0;
   logic       err_clr = 1'b0;
   logic [2:0] level;
   logic       level_vld, bubble_err, lock, frame_done;
   logic [7:0] err_cnt;

   always #5 dac_clk = ~dac_clk;

   dac_thermo_rx #(.LOCK_FRAMES(LOCK_FRAMES), .MISS_LIMIT(MISS_LIMIT)) dut (
      .dac_clk    (dac_clk),
      .dac_rst_n  (dac_rst_n),
      .en         (en),
      .b_in       (b_in),
      .err_clr    (err_clr),
      .level      (level),
      .level_vld  (level_vld),
      .bubble_err (bubble_err),
      .lock       (lock),
      .frame_done (frame_done),
      .err_cnt    (err_cnt)
   );

   typedef struct {
      logic [3:0] code;
      int         lvl;
      int         bub;
   } dec_vec_t;

   int errors = 0;
   int checks = 0;

   int frame_tbl [8] = '{0, 1, 3, 7, 15, 0, 0, 0};
   int tx_phase;

   // behavioural model
   int m_state;  // 0 hunt, 1 align, 2 locked
   int m_phase, m_good, m_miss, m_err, m_level;
   bit m_prev0, m_vld, m_bub, m_lock, m_fd;
   int pipe [$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_thermo(input int c);
      int n;
      n = $countones(4'(c));
      return c == ((1 << n) - 1);
   endfunction

   task automatic model_reset();
      pipe.delete();
      for (int i = 0; i < D; i++) pipe.push_back(0);
      m_state = 0; m_phase = 0; m_good = 0; m_miss = 0; m_err = 0;
      m_level = 0; m_prev0 = 0; m_vld = 0; m_bub = 0; m_lock = 0; m_fd = 0;
   endtask

   task automatic model_edge(input int b, input bit e, input bit clr);
      int s, np;
      bit mis;
      m_fd = 0;
      if (e) begin
         s = pipe.pop_front();
         pipe.push_back(b);
         m_vld   = 1;
         m_bub   = !is_thermo(s);
         m_level = m_bub ? 0 : $countones(4'(s));
         np  = (m_phase + 1) % 8;
         mis = (s != frame_tbl[np]);
         if (m_state == 0) begin
            if (s == 1 && m_prev0) begin
               m_state = 1; m_phase = 1; m_good = 0;
            end
         end else if (m_state == 1) begin
            if (mis) begin
               m_state = 0; m_good = 0;
            end else begin
               m_phase = np;
               if (np == 0) begin
                  m_good++;
                  if (m_good >= LOCK_FRAMES) begin
                     m_state = 2; m_good = 0; m_miss = 0;
                  end
               end
            end
         end else begin
            m_fd    = (np == 0);
            m_phase = np;
            if (mis) begin
               if (m_err < 255) m_err++;
               m_miss++;
               if (m_miss >= MISS_LIMIT) begin
                  m_state = 0; m_miss = 0;
               end
            end else begin
               m_miss = 0;
            end
         end
         m_prev0 = (s == 0);
      end else begin
         m_vld = 0;
      end
      if (clr) m_err = 0;
      m_lock = (m_state == 2);
   endtask

   task automatic step(input logic [3:0] b, input bit e, input bit clr);
      b_in = b; en = e; err_clr = clr;
      @(posedge dac_clk);
      model_edge(int'(b), e, clr);
      #1;
      chk("level",      int'(level),      m_level);
      chk("level_vld",  int'(level_vld),  int'(m_vld));
      chk("bubble_err", int'(bubble_err), int'(m_bub));
      chk("lock",       int'(lock),       int'(m_lock));
      chk("frame_done", int'(frame_done), int'(m_fd));
      chk("err_cnt",    int'(err_cnt),    m_err);
   endtask

   task automatic send(input logic [3:0] code, input bit clr);
      step(code, 1'b1, clr);
      tx_phase = (tx_phase + 1) % 8;
   endtask

   task automatic send_clean(input int n);
      for (int i = 0; i < n; i++) send(4'(frame_tbl[tx_phase]), 1'b0);
   endtask

   task automatic do_reset();
      dac_rst_n = 1'b0; en = 1'b0; err_clr = 1'b0; b_in = 4'd0;
      model_reset();
      tx_phase = 0;
      @(posedge dac_clk);
      @(posedge dac_clk);
      #1;
      dac_rst_n = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"},      int'(level),      0);
      chk({tag, "_level_vld"},  int'(level_vld),  0);
      chk({tag, "_bubble_err"}, int'(bubble_err), 0);
      chk({tag, "_lock"},       int'(lock),       0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_err_cnt"},    int'(err_cnt),    0);
   endtask

   dec_vec_t tbl [16];

   initial begin
      int fd_count, lat, saved_err, r;
      bit reached;
      logic [3:0] code;

      tbl[0]  = '{4'b0000, 0, 0}; tbl[1]  = '{4'b0001, 1, 0};
      tbl[2]  = '{4'b0010, 0, 1}; tbl[3]  = '{4'b0011, 2, 0};
      tbl[4]  = '{4'b0100, 0, 1}; tbl[5]  = '{4'b0101, 0, 1};
      tbl[6]  = '{4'b0110, 0, 1}; tbl[7]  = '{4'b0111, 3, 0};
      tbl[8]  = '{4'b1000, 0, 1}; tbl[9]  = '{4'b1001, 0, 1};
      tbl[10] = '{4'b1010, 0, 1}; tbl[11] = '{4'b1011, 0, 1};
      tbl[12] = '{4'b1100, 0, 1}; tbl[13] = '{4'b1101, 0, 1};
      tbl[14] = '{4'b1110, 0, 1}; tbl[15] = '{4'b1111, 4, 0};

      model_reset();
      tx_phase = 0;
      repeat (2) @(posedge dac_clk);
      #1;
      chk_all_zero("reset");
      dac_rst_n = 1'b1;

      // decode table
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k <= D; k++) step(tbl[i].code, 1'b1, 1'b0);
         chk("dec_level",  int'(level),      tbl[i].lvl);
         chk("dec_bubble", int'(bubble_err), tbl[i].bub);
      end

      // lock acquisition from reset
      do_reset();
      for (int n = 1; n <= 24 + D; n++) begin
         send_clean(1);
         chk("lock_rise", int'(lock), (n >= 17 + D) ? 1 : 0);
      end
      chk("lock_err0", int'(err_cnt), 0);
      fd_count = 0;
      for (int n = 0; n < 24; n++) begin
         send_clean(1);
         fd_count += int'(frame_done);
      end
      chk("fd_per_frame", fd_count, 3);

      // bubble at phase 3 while locked
      while (tx_phase != 3) send_clean(1);
      send(4'b0101, 1'b0);
      send_clean(D);
      chk("bub_flag",  int'(bubble_err), 1);
      chk("bub_level", int'(level),      0);
      chk("bub_err",   int'(err_cnt),    1);
      chk("bub_lock",  int'(lock),       1);

      // three consecutive misses drop lock, then relock
      send(4'(frame_tbl[tx_phase]), 1'b1);
      chk("clr_err", int'(err_cnt), 0);
      send_clean(4);
      for (int i = 0; i < 3; i++) send(4'b1010, 1'b0);
      send_clean(D);
      chk("miss_lock", int'(lock),    0);
      chk("miss_err",  int'(err_cnt), 3);
      send_clean(32);
      chk("relock",     int'(lock),    1);
      chk("relock_err", int'(err_cnt), 3);

      // en low for 5 cycles mid-frame
      while (tx_phase != 2) send_clean(1);
      for (int i = 0; i < 5; i++) begin
         step(4'($urandom_range(0, 15)), 1'b0, 1'b0);
         chk("en_vld", int'(level_vld),  0);
         chk("en_fd",  int'(frame_done), 0);
      end
      send_clean(16);
      chk("en_resume_err",  int'(err_cnt), 3);
      chk("en_resume_lock", int'(lock),    1);

      // saturation and clear-wins
      reached = 0;
      for (int k = 0; k < 2000 && !reached; k++) begin
         code = (k % 3 != 2) ? 4'b1010 : 4'(frame_tbl[tx_phase]);
         send(code, 1'b0);
         reached = (m_err == 255);
      end
      chk("sat_reach", int'(err_cnt), 255);
      send_clean(4);
      send(4'b1010, 1'b0);
      send_clean(D);
      chk("sat_hold", int'(err_cnt), 255);
      chk("sat_lock", int'(lock),    1);
      send(4'b1010, 1'b0);
      for (int j = 0; j < D; j++) send(4'(frame_tbl[tx_phase]), j == D - 1);
      chk("clr_wins", int'(err_cnt), 0);

      // async reset mid-frame while locked
      send_clean(3);
      saved_err = int'(lock);
      chk("pre_rst_lock", saved_err, 1);
      #2;
      dac_rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      model_reset();
      tx_phase = 0;
      @(posedge dac_clk);
      #1;
      dac_rst_n = 1'b1;

      // level latency
      lat = 0;
      step(4'b0111, 1'b1, 1'b0);
      for (int n = 1; n <= 10 && lat == 0; n++) begin
         if (level == 3'd3) lat = n;
         else step(4'b0000, 1'b1, 1'b0);
      end
      chk("level_latency", lat, LAT_EDGES);
      tx_phase = 0;
      send_clean(8);
      chk("fresh_nolock", int'(lock), 0);
      send_clean(24);
      chk("fresh_lock", int'(lock), 1);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) do_reset();
         r = int'($urandom_range(0, 99));
         if (r < 8) begin
            step(4'($urandom_range(0, 15)), 1'b0, 1'b0);
         end else begin
            code = 4'(frame_tbl[tx_phase]);
            if (r < 12) code = 4'($urandom_range(0, 15));
            if (r == 12) tx_phase = (tx_phase + 1) % 8;
            send(code, r == 13);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dac_thermo_rx.md
DAC_THERMO_RX -- requirements
Module: dac_thermo_rx

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 2: consecutive error-free frames needed to declare lock (range 1..15).
REQ-002 SHALL have parameter MISS_LIMIT, default 3: consecutive mismatching samples in LOCKED that force loss of lock (range 1..7).
REQ-003 SHALL have port dac_clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port dac_rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1: sample enable; low freezes all state and deasserts level_vld.
REQ-006 SHALL have port b_in, input, 4: thermometer code from the DAC driver.
REQ-007 SHALL have port err_clr, input, 1: synchronous clear of err_cnt.
REQ-008 SHALL have port level, output, 3: binary count of ones in the decoded code, 0..4.
REQ-009 SHALL have port level_vld, output, 1: level is updated this cycle.
REQ-010 SHALL have port bubble_err, output, 1: sampled code is not one of 0000/0001/0011/0111/1111.
REQ-011 SHALL have port lock, output, 1: high in LOCKED state.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse at the end of each frame received while LOCKED.
REQ-013 SHALL have port err_cnt, output, 8: saturating count of mismatches while LOCKED.

Function
REQ-014 Expected frame SHALL be 8 samples, phase 0..7: 0000,0001,0011,0111,1111,0000,0000,0000; then repeats.
REQ-015 b_in SHALL be registered when en=1 (b_q); level, level_vld and bubble_err SHALL be registered from b_q one edge later (2-edge latency).
REQ-016 For a bubble code, level SHALL be 0 and bubble_err 1; a bubble SHALL count as a mismatch.
REQ-017 FSM states SHALL be HUNT, ALIGN, LOCKED.
REQ-018 HUNT: a 0001 sample directly preceded by a 0000 sample SHALL set phase=1 and enter ALIGN; otherwise remain.
REQ-019 ALIGN: each sample SHALL be compared to the expected code at phase+1; match advances phase mod 8; any mismatch returns to HUNT and clears the good-frame count.
REQ-020 ALIGN: each 7->0 phase wrap with no mismatch SHALL increment the good-frame count; reaching LOCK_FRAMES SHALL enter LOCKED.
REQ-021 LOCKED: phase SHALL advance every enabled sample regardless of match; a mismatch increments err_cnt (saturating at 255) and miss_run; a match clears miss_run.
REQ-022 LOCKED: miss_run reaching MISS_LIMIT SHALL enter HUNT, deassert lock the next cycle, and leave err_cnt unchanged.
REQ-023 frame_done SHALL pulse on each 7->0 wrap in LOCKED, including frames with mismatches.
REQ-024 err_clr coincident with a mismatch SHALL result in err_cnt=0 (clear wins).
REQ-025 en=0 SHALL hold phase, state, and counters; level_vld SHALL be 0 and frame_done SHALL be 0.

Reset
REQ-026 On dac_rst_n low: state=HUNT, phase=0, b_q=0000, level=0, level_vld=0, bubble_err=0, lock=0, frame_done=0, err_cnt=0, miss_run=0, good-frame count=0.
REQ-027 Reset mid-frame SHALL take effect immediately; after release, lock SHALL require a fresh HUNT/ALIGN sequence.

Configuration
REQ-028 With DAC_THERMO_RX_SYNC_EN defined, b_in SHALL pass through a 2-flop synchronizer (reset to 0000) ahead of b_q, adding 2 cycles of latency; without it, b_in feeds b_q directly.

Structure
REQ-029 Package dac_pkg SHALL hold the state enum, the 8-entry expected-code table, and the valid thermometer code constants.
REQ-030 Sub-module thermo2bin SHALL be a combinational block: 4-bit code in; 3-bit level and bubble flag out.

Verification
REQ-031 Two clean frames from reset -> lock rises during the third frame at the ALIGN-to-LOCKED transition; err_cnt=0; frame_done pulses once per frame thereafter.
REQ-032 Inject 0101 at phase 3 while LOCKED -> bubble_err=1, level=0, err_cnt=1, lock stays 1.
REQ-033 Three consecutive wrong samples while LOCKED (MISS_LIMIT=3) -> lock falls, err_cnt=3; relock after two clean frames.
REQ-034 Drop en for 5 cycles mid-frame -> level_vld=0, phase held; resuming the frame gives no mismatch.
REQ-035 err_cnt at 255 plus a further mismatch -> stays 255; err_clr on the same cycle as a mismatch -> 0.
REQ-036 Assert dac_rst_n low mid-frame while LOCKED -> all outputs reset immediately; with the SYNC_EN macro, level latency is measured as 4 edges.
